dcache_wb: RTL

Parametrised direct-mapped, write-back, write-allocate data cache between the CPU data port and a multi-cycle main memory. It replaces the fixed-size cache inside the data memory path and keeps the CPU-side signals (`address`, `writeData`, `memWrite`, `memRead`, `readData`, `dataReady`). Main memory gets a req/ack handshake, so any memory latency is tolerated. Dirty lines are written back only on eviction.

---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_tag_array.sv | 48 ++++
 rtl/dcache_wb.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM type, counter width and address-split helpers for dcache_wb
// Helpers take the address zero-extended to 64 bits plus the index width,
// so callers size the result with a cast to their own IDX_W / TAG_W.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    localparam int CNT_W = 32;

    function automatic logic [63:0] addr_index(input logic [63:0] a, input int idx_w);
        return (a >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] a, input int idx_w);
        return a >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// dcache_tag_array: per-line valid/dirty/tag storage for dcache_wb
// Ports:
//   clk, rst_n          clock, async active-low reset (clears valid/dirty only)
//   idx                 line index, shared by the read and write port
//   valid, dirty, tag   combinational read of line idx
//   we, wdirty, wtag    write line idx: valid<=1, dirty<=wdirty, tag<=wtag
module dcache_tag_array
    import dcache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic             dirty,
    output logic [TAG_W-1:0] tag,
    input  logic             we,
    input  logic             wdirty,
    input  logic [TAG_W-1:0] wtag
);

    logic [LINES-1:0] v, d;
    logic [TAG_W-1:0] tags [LINES];

    assign valid = v[idx];
    assign dirty = d[idx];
    assign tag   = tags[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            d <= '0;
        end else if (we) begin
            v[idx] <= 1'b1;
            d[idx] <= wdirty;
        end
    end

    // Tags are meaningless while valid=0, so they are left unreset.
    always_ff @(posedge clk) begin
        if (we)
            tags[idx] <= wtag;
    end

endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back, write-allocate data cache with req/ack main-memory port
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   address, writeData         CPU byte address (bits [1:0] ignored), store data
//   memWrite, memRead          CPU store / load request (store wins if both)
//   readData, dataReady        load result, one-cycle completion pulse
//   mem_req, mem_we            memory request (held until mem_ack), 1 = write-back
//   mem_addr, mem_wdata        word-aligned memory address, write-back data
//   mem_rdata, mem_ack         fill data, one-cycle acknowledge
//   hit_count, miss_count,     saturating statistics, present only when
//   wb_count                   DCACHE_STATS_EN is defined
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int LINES  = 64,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              memWrite,
    input  logic              memRead,
    output logic [DATA_W-1:0] readData,
    output logic              dataReady,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef DCACHE_STATS_EN
   ,output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  wb_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    state_t            state;
    logic [ADDR_W-1:0] lat_addr, cur_addr;
    logic [DATA_W-1:0] lat_wdata, line_data, dat_wd;
    logic              lat_we;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag, line_tag, arr_tag;
    logic              line_valid, line_dirty, hit, vic_dirty;
    logic              idle_req, install, wb_clean, fill_done, arr_we, dat_we;
    logic [DATA_W-1:0] data [LINES];

    // Lookup uses the live address while idle, the latched one while servicing.
    assign cur_addr  = (state == IDLE) ? address : lat_addr;
    assign idx       = IDX_W'(addr_index(64'(cur_addr), IDX_W));
    assign tag       = TAG_W'(addr_tag(64'(cur_addr), IDX_W));
    assign line_data = data[idx];
    assign hit       = line_valid && (line_tag == tag);
    assign vic_dirty = line_valid && line_dirty;

    // dataReady is still high in the first idle cycle; skipping that cycle keeps
    // a request held through the pulse from being executed twice.
    assign idle_req  = (state == IDLE) && !dataReady && (memRead || memWrite);
    assign install   = (idle_req && memWrite && (hit || !vic_dirty)) ||
                       ((state == WB) && mem_ack && lat_we);
    assign wb_clean  = (state == WB) && mem_ack && !lat_we;
    assign fill_done = (state == FILL) && mem_ack;
    assign arr_we    = install || wb_clean || fill_done;
    assign arr_tag   = wb_clean ? line_tag : tag;
    assign dat_we    = install || fill_done;
    assign dat_wd    = fill_done ? mem_rdata : ((state == IDLE) ? writeData : lat_wdata);

    dcache_tag_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk    (clk),
        .rst_n  (rst_n),
        .idx    (idx),
        .valid  (line_valid),
        .dirty  (line_dirty),
        .tag    (line_tag),
        .we     (arr_we),
        .wdirty (install),
        .wtag   (arr_tag)
    );

    always_ff @(posedge clk) begin
        if (dat_we)
            data[idx] <= dat_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            readData  <= '0;
            dataReady <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            dataReady <= 1'b0;
            case (state)
                IDLE: if (idle_req) begin
                    lat_addr  <= {address[ADDR_W-1:2], 2'b00};
                    lat_wdata <= writeData;
                    lat_we    <= memWrite;
                    if (hit) begin
                        if (!memWrite)
                            readData <= line_data;
                        state <= RESP;
                    end else if (vic_dirty) begin
                        state     <= WB;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {line_tag, idx, 2'b00};
                        mem_wdata <= line_data;
                    end else if (memWrite) begin
                        state <= RESP;
                    end else begin
                        state    <= FILL;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {address[ADDR_W-1:2], 2'b00};
                    end
                end
                // A load keeps mem_req high and turns straight into the fill.
                WB: if (mem_ack) begin
                    mem_req  <= !lat_we;
                    mem_we   <= 1'b0;
                    mem_addr <= lat_addr;
                    state    <= lat_we ? RESP : FILL;
                end
                FILL: if (mem_ack) begin
                    mem_req  <= 1'b0;
                    readData <= mem_rdata;
                    state    <= RESP;
                end
                default: begin
                    dataReady <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (idle_req && hit && !(&hit_count))
                hit_count <= hit_count + CNT_W'(1);
            if (idle_req && !hit && !(&miss_count))
                miss_count <= miss_count + CNT_W'(1);
            if ((state == WB) && mem_ack && !(&wb_count))
                wb_count <= wb_count + CNT_W'(1);
        end
    end
`endif

endmodule
